// File: rtl/result_trace_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : result_trace_buffer
//  Purpose  : Captures {PC, writeback result} records from a single-cycle
//             core into a small FIFO and serialises them MSB-first as a byte
//             stream with a valid/ready handshake. A full FIFO drops the
//             newest record and counts it, so the core is never stalled.
//  Revision : 1.0  initial release
// ============================================================================
module result_trace_buffer #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   pc_in,
  input  logic [31:0]   result_in,
  input  logic          capture_en,
  output logic [7:0]    out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW:0]   level,
  output logic          overflow,
  output logic [7:0]    drop_count
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [63:0]   mem_q [DEPTH];
  logic [63:0]   shift_q, shift_d;
  logic [2:0]    byte_idx_q, byte_idx_d;
  logic [AW:0]   level_q, level_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    drop_q, drop_d;

  logic          fifo_empty;
  logic          fifo_full;
  logic          pop;
  logic          push;
  logic          drop;
  logic          handshake;
  logic [63:0]   rd_data;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_data    = mem_q[rd_ptr_q[AW-1:0]];

  assign out_valid  = (state_q == ST_SEND);
  assign out_data   = shift_q[63:56];
  assign handshake  = out_valid && out_ready;

  // A pop in the same cycle frees the slot, so a push into a full FIFO
  // is only dropped when the serialiser is not taking a record.
  assign push = capture_en && (!fifo_full || pop);
  assign drop = capture_en && fifo_full && !pop;

  assign level      = level_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_q;

  // Serialiser next-state: load a record, shift out bytes, chain records.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    byte_idx_d = byte_idx_q;
    pop        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_d    = rd_data;
          byte_idx_d = 3'd0;
          state_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        if (handshake) begin
          if (byte_idx_q != 3'd7) begin
            shift_d    = {shift_q[55:0], 8'h00};
            byte_idx_d = byte_idx_q + 3'd1;
          end else if (!fifo_empty) begin
            // Chain straight into the next record with no idle gap.
            pop        = 1'b1;
            shift_d    = rd_data;
            byte_idx_d = 3'd0;
          end else begin
            state_d    = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FIFO bookkeeping: pointers, occupancy and drop statistics.
  always_comb begin
    wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, pop};
    level_d    = wr_ptr_d - rd_ptr_d;
    overflow_d = overflow_q | drop;
    drop_d     = drop_q;
    if (drop && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  // State and control registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      shift_q    <= '0;
      byte_idx_q <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      shift_q    <= shift_d;
      byte_idx_q <= byte_idx_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  // Record storage; contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (push && reset) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {pc_in, result_in};
    end
  end

endmodule
`default_nettype wire

// File: doc/result_trace_buffer.md
# result_trace_buffer

Downstream consumer of the single-cycle MIPS core's per-cycle outputs: captures each retired instruction's PC (`inPc1`) and writeback value (`result`) into a record FIFO and serialises the records as a byte stream with a valid/ready handshake toward a debug UART or trace port. It decouples the core, which retires one instruction every cycle, from a slow trace sink. Overflow drops the newest records and counts them, so the core never stalls.

## Interface
- `DEPTH`, 8: record FIFO depth. Power of two, ≥ 2.
- `AW`, 3: log2(DEPTH).

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-low reset (0 = reset).
- `pc_in`  in  32  PC of the retiring instruction (core `inPc1`).
- `result_in`  in  32  writeback value (core `result`).
- `capture_en`  in  1  sample {pc_in, result_in} this cycle.
- `out_data`  out  8  current trace byte.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  sink accepts the byte when high together with `out_valid`.
- `level`  out  AW+1  records held in the FIFO. Excludes the record in the serialiser.
- `overflow`  out  1  sticky flag: at least one record has been dropped since reset.
- `drop_count`  out  8  number of dropped records. Saturates at 255.

## Operation
- Record is 64 bits: {pc_in, result_in}. Bytes are sent MSB first: pc[31:24] … pc[7:0], then result[31:24] … result[7:0]. Byte index runs 0..7.
- Push: `capture_en`=1 and FIFO not full writes the record and increments the write pointer.
- Push when full: the record is discarded and the FIFO is unchanged. `overflow` is set and `drop_count` increments, stopping at 255.
- Simultaneous push and pop while full: the pop frees a slot in the same cycle, so the push is accepted and nothing is dropped. `level` is unchanged.
- Pointers are AW+1 bits. Wrap-around is natural modulo 2^(AW+1). The FIFO is full when the MSBs differ and the lower bits are equal.
- Serialiser FSM, two states:
  - IDLE: `out_valid`=0. If the FIFO is non-empty, pop into the 64-bit shift register, clear byte_idx, and go to SEND.
  - SEND: `out_valid`=1 and `out_data` = the shift register's top byte.
  - On `out_valid & out_ready` with byte_idx<7: shift left 8 and increment byte_idx.
  - On handshake with byte_idx==7: if the FIFO is non-empty, pop the next record in that same cycle and stay in SEND with byte_idx=0. Otherwise go to IDLE.
- `out_data` and `out_valid` must not change while `out_valid`=1 and `out_ready`=0.
- `level` = write pointer − read pointer, 0..DEPTH.

## Timing
- Reset values: `out_valid`=0, `out_data`=8'h00, `level`=0, `overflow`=0, `drop_count`=0, FSM=IDLE, pointers=0, byte_idx=0.
- Reset mid-operation clears everything on the next edge. A partially sent record is abandoned. FIFO contents become don't-care.
- Latency, with the FIFO empty, the FSM in IDLE, and `capture_en` high in cycle c:
  - record written at the end of cycle c;
  - popped at the end of cycle c+1;
  - byte 0 is valid in cycle c+2.
- Throughput: 1 byte per cycle when `out_ready`=1 continuously. Back-to-back records need no idle cycle between byte 7 and the next byte 0.
- Sustained capture: a full-rate core outruns the 8-cycles-per-record drain. Drops are the expected behaviour, not an error.
- `level`, `overflow` and `drop_count` are registered and reflect the previous edge.

## Test plan
- **Single record:**
  - Stimulus: after reset, `capture_en` pulses once with pc=32'h0000_0004 and result=32'hDEAD_BEEF; `out_ready`=1.
  - Required response: bytes 00,00,00,04,DE,AD,BE,EF on cycles c+2..c+9; then `out_valid`=0 and `level`=0.
- **Back-pressure:**
  - Stimulus: same record, `out_ready` toggling 1,0,0,1,…
  - Required response: `out_data` is held on stall cycles; the byte sequence is identical to the single-record case; no byte is duplicated or skipped.
- **Overflow:**
  - Stimulus: `out_ready`=0, `capture_en`=1 for 12 cycles with pc=4·k and result=k.
  - Required response:
    - record 0 sits in the serialiser;
    - records 1..8 fill the FIFO and `level`=8;
    - records 9..11 are dropped: `drop_count`=3, `overflow`=1;
    - after releasing `out_ready`, records 0..8 emerge in order.
- **Full plus simultaneous pop:**
  - Stimulus: FIFO full, serialiser finishing byte 7 with `out_ready`=1, and `capture_en`=1 in the same cycle.
  - Required response: the record is accepted, `drop_count` is unchanged, and `level` stays 8.
- **Saturation:**
  - Stimulus: `out_ready`=0 and 300 consecutive captures.
  - Required response: `drop_count`=255 and holds.
- **Reset mid-record:**
  - Stimulus: assert `reset`=0 for one cycle after byte 3 of a record.
  - Required response: next cycle `out_valid`=0, `level`=0, `overflow`=0, `drop_count`=0; a new capture restarts at byte 0.
